// File: rtl/aes_sr_mc_ark_stage_if.sv
// aes_sr_mc_ark_stage_if: block input, SubBytes result and ready/valid output bus of the round stage.
interface aes_sr_mc_ark_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] round_key;
    logic         last_round;
    logic [127:0] sb_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    modport master (
        output in_valid, round_key, last_round, sb_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, round_key, last_round, sb_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes_sr_mc_ark_stage.sv
// aes_sr_mc_ark_stage: ShiftRows/MixColumns/AddRoundKey behind a stall-free SubBytes pipe, credit-guarded output FIFO.
// Define AES_STAGE_ERR_EN to add the sticky overflow flag err.
module aes_sr_mc_ark_stage #(
    parameter int SBOX_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef AES_STAGE_ERR_EN
    output logic err,
`endif
    aes_sr_mc_ark_stage_if.slave io_bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = $clog2(SBOX_LAT + 1);

    logic          r_tag_v    [SBOX_LAT];
    logic [127:0]  r_tag_key  [SBOX_LAT];
    logic          r_tag_last [SBOX_LAT];
    logic [128:0]  r_mem      [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] w_inflight;
    logic [7:0]    w_sb [16];
    logic [7:0]    w_sr [16];
    logic [7:0]    w_mc [16];
    logic [127:0]  w_res;
    logic          w_acc;
    logic          w_rd;
    logic          w_full;
    logic          w_wr;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both FIFO entries and blocks still inside SubBytes, from registers only.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < SBOX_LAT; k++) w_inflight = w_inflight + IW'(r_tag_v[k]);
    end

    assign io_bus.in_ready = (32'(r_count) + 32'(w_inflight)) < 32'(FIFO_DEPTH);
    assign w_acc  = io_bus.in_valid && io_bus.in_ready;
    assign w_rd   = io_bus.out_valid && io_bus.out_ready;
    assign w_full = r_count == CW'(FIFO_DEPTH);
    assign w_wr   = r_tag_v[SBOX_LAT-1] && (!w_full || w_rd);
    assign io_bus.out_valid = r_count != '0;
    assign {io_bus.out_last, io_bus.out_data} = r_mem[r_rd_ptr];

    always_comb begin
        for (int i = 0; i < 16; i++) w_sb[i] = io_bus.sb_data[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_mc[4*c+r] = xt(w_sr[4*c+r]) ^ xt(w_sr[4*c+(r+1)%4]) ^ w_sr[4*c+(r+1)%4]
                            ^ w_sr[4*c+(r+2)%4] ^ w_sr[4*c+(r+3)%4];
        for (int i = 0; i < 16; i++)
            w_res[127-8*i -: 8] = (r_tag_last[SBOX_LAT-1] ? w_sr[i] : w_mc[i]) ^ r_tag_key[SBOX_LAT-1][127-8*i -: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SBOX_LAT; k++) begin
                r_tag_v[k]    <= 1'b0;
                r_tag_key[k]  <= '0;
                r_tag_last[k] <= 1'b0;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_tag_v[0]    <= w_acc;
            r_tag_key[0]  <= io_bus.round_key;
            r_tag_last[0] <= io_bus.last_round;
            for (int k = 1; k < SBOX_LAT; k++) begin
                r_tag_v[k]    <= r_tag_v[k-1];
                r_tag_key[k]  <= r_tag_key[k-1];
                r_tag_last[k] <= r_tag_last[k-1];
            end
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {r_tag_last[SBOX_LAT-1], w_res};
                r_wr_ptr        <= nxt(r_wr_ptr);
            end
            if (w_rd) r_rd_ptr <= nxt(r_rd_ptr);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

`ifdef AES_STAGE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (r_tag_v[SBOX_LAT-1] && w_full && !w_rd) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_aes_sr_mc_ark_stage.sv
// tb_aes_sr_mc_ark_stage: vector table plus scoreboarded streaming, backpressure and reset sequences.
module tb_aes_sr_mc_ark_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0, cyc = 0, pops = 0, pop_first = 0, pop_last = 0;
    logic [127:0] sb_in = '0;
    logic [127:0] sbp0 = '0;
    logic [128:0] q[$];
    logic [128:0] exp_e;
    logic         hold_v = 1'b0;
    logic [128:0] hold_d = '0;

    aes_sr_mc_ark_stage_if bus();
`ifdef AES_STAGE_ERR_EN
    logic err;
`endif
    aes_sr_mc_ark_stage #(.SBOX_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef AES_STAGE_ERR_EN
        .err(err),
`endif
        .io_bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the 2-cycle SubBytes pipe: only accepted blocks enter it.
    always @(posedge clk) begin
        sbp0        <= (bus.in_valid && bus.in_ready) ? sb_in : '0;
        bus.sb_data <= sbp0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] sb, input logic [127:0] key, input logic last);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = sb[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = last ? t[r][c] :
                    gmul(t[r][c], 8'd2) ^ gmul(t[(r+1)%4][c], 8'd3) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
        return o ^ key;
    endfunction

    task automatic chk(input string n, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] sb, input logic [127:0] key, input logic last,
                        input logic [128:0] e, output logic acc);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b1;
        bus.round_key  = key;
        bus.last_round = last;
        sb_in          = sb;
        acc            = bus.in_ready;
        if (acc) q.push_back(e);
    endtask

    task automatic send_rand(output logic acc);
        logic [127:0] sb, key;
        logic last;
        sb   = {$urandom, $urandom, $urandom, $urandom};
        key  = {$urandom, $urandom, $urandom, $urandom};
        last = 1'($urandom_range(0, 1));
        send(sb, key, last, {last, model(sb, key, last)}, acc);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string n);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk(n, 129'(q.size()), 129'd0);
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) hold_v = 1'b0;
        else begin
            if (hold_v) chk("hold_stable", {bus.out_last, bus.out_data}, hold_d);
            hold_v = bus.out_valid && !bus.out_ready;
            hold_d = {bus.out_last, bus.out_data};
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %h want none", {bus.out_last, bus.out_data});
                end else begin
                    exp_e = q.pop_front();
                    if ({bus.out_last, bus.out_data} !== exp_e) begin
                        errors++;
                        $display("FAIL scoreboard got %h want %h", {bus.out_last, bus.out_data}, exp_e);
                    end
                end
                pops++;
                if (pops == 1) pop_first = cyc;
                pop_last = cyc;
            end
        end
    end

    typedef struct {
        logic [127:0] sb;
        logic [127:0] key;
        logic         last;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[4];

    initial begin
        logic acc;
        int   nacc;
        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                    128'ha49c7ff2689f352b6b5bea43026a5049};
        vecs[1] = '{128'h0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                    128'h000102030405060708090a0b0c0d0e0f};
        vecs[2] = '{{16{8'h01}}, 128'h0, 1'b0, {16{8'h01}}};
        vecs[3] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'h0, 1'b1,
                    128'hd4bf5d30e0b452aeb84111f11e2798e5};
        bus.in_valid   = 1'b0;
        bus.round_key  = '0;
        bus.last_round = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 129'(bus.out_valid), 129'd0);
        chk("rst_out_data", 129'(bus.out_data), 129'd0);
        chk("rst_out_last", 129'(bus.out_last), 129'd0);
        chk("rst_in_ready", 129'(bus.in_ready), 129'd1);

        // Known vectors, each checked for 3-cycle latency to out_valid.
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].sb, vecs[v].key, vecs[v].last, {vecs[v].last, vecs[v].exp}, acc);
            chk("vec_accept", 129'(acc), 129'd1);
            idle();
            @(negedge clk);
            chk("lat_c1", 129'(bus.out_valid), 129'd0);
            @(negedge clk);
            chk("lat_c2", 129'(bus.out_valid), 129'd0);
            @(negedge clk);
            chk("lat_c3", 129'(bus.out_valid), 129'd1);
            wait_drain("vec_drain");
        end

        // Backpressure: credits must cap acceptance at FIFO_DEPTH.
        bus.out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            send_rand(acc);
            if (acc) nacc++;
        end
        chk("bp_accepted", 129'(nacc), 129'd4);
        chk("bp_in_ready_low", 129'(bus.in_ready), 129'd0);
        idle();
        repeat (4) @(negedge clk);
        chk("bp_full_valid", 129'(bus.out_valid), 129'd1);
        chk("bp_still_low", 129'(bus.in_ready), 129'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        chk("bp_ready_same_cycle", 129'(bus.in_ready), 129'd0);
        @(posedge clk);
        #1 chk("bp_ready_next_cycle", 129'(bus.in_ready), 129'd1);
        wait_drain("bp_drain");

        // Streaming: 20 back-to-back blocks, one output per cycle.
        pops = 0;
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            send_rand(acc);
            if (acc) nacc++;
        end
        idle();
        wait_drain("stream_drain");
        chk("stream_accepted", 129'(nacc), 129'd20);
        chk("stream_pops", 129'(pops), 129'd20);
        chk("stream_contiguous", 129'(pop_last - pop_first), 129'd19);

        // Reset with 2 blocks in the delay line and 2 in the FIFO.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(acc);
        idle();
        chk("pre_rst_valid", 129'(bus.out_valid), 129'd1);
        rst = 1'b1;
        #1;
        chk("rst_now_valid", 129'(bus.out_valid), 129'd0);
        chk("rst_now_data", 129'(bus.out_data), 129'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) nacc++;
        end
        chk("post_rst_no_stale", 129'(nacc), 129'd0);
        chk("post_rst_in_ready", 129'(bus.in_ready), 129'd1);
        send(vecs[0].sb, vecs[0].key, vecs[0].last, {vecs[0].last, vecs[0].exp}, acc);
        chk("post_rst_accept", 129'(acc), 129'd1);
        idle();
        wait_drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
